jtpopeye_dma: RTL and testbench

Sprite DMA engine sitting between the main CPU board and the object (sprite) RAM. On each vertical-blank rising edge it requests the Z80 bus, reads a block of sprite attributes out of the upper 1 KB of main work RAM through the CPU board's DMA port, and writes them one byte per enable into object RAM. It then releases the bus. It drives `busrq_n`, `dma_cs` and `AD_DMA` into the main board and consumes `busak_n` and `DD_DMA` from it.

---
 rtl/jtpopeye_pkg.sv | 18 +
 rtl/jtpopeye_dma.sv | 129 ++++++++++++
 tb/tb_jtpopeye_dma.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye sprite DMA.
//   dma_st_e    : DMA sequencer states
//   DMA_LEN_DEF : default bytes per vertical-blank transfer
//   OBJ_AW      : object RAM / DMA offset address width
package jtpopeye_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FLUSH,
    ST_REL
  } dma_st_e;

  localparam int DMA_LEN_DEF = 640;
  localparam int OBJ_AW      = 10;

endpackage

// File: rtl/jtpopeye_dma.sv
// Sprite DMA: on each VB rising edge, request the Z80 bus, copy LEN bytes
// from the upper 1 KB of main RAM into object RAM, then release the bus.
// Ports:
//   clk, rst_n (async, active low), cen (CPU clock enable)
//   VB        : vertical blank level
//   busrq_n   : Z80 bus request (out)    busak_n : Z80 bus acknowledge (in)
//   dma_cs    : selects AD_DMA on the main RAM address mux
//   AD_DMA    : main RAM byte offset     DD_DMA  : main RAM data, 1-cen latency
//   obj_addr, obj_din, obj_we : object RAM write port, obj_we is a 1-clk pulse
//   busy      : trigger accepted and bus not yet released
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter int LEN = DMA_LEN_DEF,
  parameter int AW  = OBJ_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          VB,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic          dma_cs,
  output logic [AW-1:0] AD_DMA,
  input  logic [7:0]    DD_DMA,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_din,
  output logic          obj_we,
  output logic          busy
);

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  dma_st_e       r_st;
  logic          r_vbl;
  logic          r_busrq_n, r_cs, r_we, r_busy;
  logic [AW-1:0] r_ad;       // doubles as the transfer counter
  logic [AW-1:0] r_rd_addr;
  logic          r_rd_vld;
  logic [AW-1:0] r_oaddr;
  logic [7:0]    r_odin;
  // While the bus is lost, DD_DMA stops tracking the staged read, so the
  // byte it carried on the first paused cen is kept here and written on
  // resume. The read of the held address is re-latched by the RAM on that
  // same resume cen, so no byte is skipped or duplicated.
  logic          r_held;
  logic [7:0]    r_hdat;

  logic          w_trig;
  assign w_trig = VB & ~r_vbl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= ST_IDLE;
      r_vbl     <= 1'b0;
      r_busrq_n <= 1'b1;
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_ad      <= '0;
      r_rd_addr <= '0;
      r_rd_vld  <= 1'b0;
      r_oaddr   <= '0;
      r_odin    <= 8'h00;
      r_held    <= 1'b0;
      r_hdat    <= 8'h00;
    end else begin
      r_we <= 1'b0;  // single clk strobe
      if (cen) begin
        r_vbl <= VB;
        case (r_st)
          ST_IDLE: if (w_trig) begin
            r_busrq_n <= 1'b0;
            r_busy    <= 1'b1;
            r_st      <= ST_REQ;
          end
          ST_REQ: if (!busak_n) begin
            r_cs     <= 1'b1;
            r_ad     <= '0;
            r_rd_vld <= 1'b0;
            r_held   <= 1'b0;
            r_st     <= ST_XFER;
          end
          ST_XFER, ST_FLUSH: begin
            if (busak_n) begin
              if (!r_held) begin
                r_held <= 1'b1;
                r_hdat <= DD_DMA;
              end
            end else begin
              r_held <= 1'b0;
              if (r_rd_vld) begin
                r_we    <= 1'b1;
                r_oaddr <= r_rd_addr;
                r_odin  <= r_held ? r_hdat : DD_DMA;
              end
              if (r_st == ST_XFER) begin
                r_rd_vld  <= 1'b1;
                r_rd_addr <= r_ad;
                if (r_ad == LAST) r_st <= ST_FLUSH;
                else              r_ad <= r_ad + 1'b1;
              end else begin
                r_rd_vld <= 1'b0;
                r_st     <= ST_REL;
              end
            end
          end
          ST_REL: begin
            r_cs      <= 1'b0;
            r_busrq_n <= 1'b1;
            r_busy    <= 1'b0;
            r_ad      <= '0;
            r_st      <= ST_IDLE;
          end
          default: r_st <= ST_IDLE;
        endcase
      end
    end
  end

  assign busrq_n  = r_busrq_n;
  assign dma_cs   = r_cs;
  assign AD_DMA   = r_ad;
  assign obj_addr = r_oaddr;
  assign obj_din  = r_odin;
  assign obj_we   = r_we;
  assign busy     = r_busy;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed bench for jtpopeye_dma: instance 0 uses LEN=640, instance 1 LEN=1024.
// Main RAM holds a ramp (data = offset[7:0]) and returns 8'hEE whenever the
// DMA does not own the bus.
module tb_jtpopeye_dma;

  logic            clk, rst_n, cen;
  logic [1:0]      vb, busak_n, busrq_n, dma_cs, obj_we, busy, clr;
  logic [1:0][9:0] ad, oaddr;
  logic [1:0][7:0] dd, odin;

  int ncmp = 0;
  int nbad = 0;
  int cen_cnt = 0;

  logic [7:0] objram [2][1024];
  int         objcnt [2][1024];
  int         wcnt[2], rqfall[2], first_wa[2], last_wa[2];
  int         last_we_cen[2], rq_rise_cen[2], max_ad[2];
  logic [1:0] prev_rq;

  for (genvar g = 0; g < 2; g++) begin : gd
    jtpopeye_dma #(.LEN(g == 0 ? 640 : 1024), .AW(10)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb[g]),
      .busrq_n(busrq_n[g]), .busak_n(busak_n[g]), .dma_cs(dma_cs[g]),
      .AD_DMA(ad[g]), .DD_DMA(dd[g]), .obj_addr(oaddr[g]),
      .obj_din(odin[g]), .obj_we(obj_we[g]), .busy(busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cen = 1'b0;
    forever @(negedge clk) cen = ~cen;
  end

  always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;

  // main RAM model, registered on cen
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (cen) dd[g] <= (dma_cs[g] && !busak_n[g]) ? ad[g][7:0] : 8'hEE;

  // object RAM and activity monitor
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      prev_rq[g] <= busrq_n[g];
      if (clr[g]) begin
        wcnt[g] <= 0; rqfall[g] <= 0; first_wa[g] <= -1; last_wa[g] <= -1;
        last_we_cen[g] <= 0; rq_rise_cen[g] <= 0; max_ad[g] <= 0;
        for (int a = 0; a < 1024; a++) begin
          objram[g][a] <= 8'h00;
          objcnt[g][a] <= 0;
        end
      end else begin
        if (obj_we[g]) begin
          if (first_wa[g] < 0) first_wa[g] <= int'(oaddr[g]);
          last_wa[g] <= int'(oaddr[g]);
          objram[g][oaddr[g]] <= odin[g];
          objcnt[g][oaddr[g]] <= objcnt[g][oaddr[g]] + 1;
          wcnt[g] <= wcnt[g] + 1;
          last_we_cen[g] <= cen_cnt;
        end
        if (prev_rq[g] && !busrq_n[g]) rqfall[g] <= rqfall[g] + 1;
        if (!prev_rq[g] && busrq_n[g]) rq_rise_cen[g] <= cen_cnt;
        if (dma_cs[g] && int'(ad[g]) > max_ad[g]) max_ad[g] <= int'(ad[g]);
      end
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step_cen();
    @(posedge clk);
    while (!cen) @(posedge clk);
    #1;
  endtask

  // One VB-triggered transfer on instance g.
  // gdly: cen with busak_n held off after busrq_n drops
  // p_at/p_len: drop busak_n for p_len cen once AD_DMA reaches p_at
  // rt_at: toggle VB around AD_DMA=rt_at; ab_at: assert reset at AD_DMA=ab_at
  task automatic run(input int g, input int gdly, input int p_at, input int p_len,
                     input int rt_at, input int ab_at);
    int  len, t0, n, w0, nd, nc;
    bit  pdone;
    len = (g == 0) ? 640 : 1024;
    clr[g] = 1'b1; step_cen(); step_cen(); clr[g] = 1'b0;
    vb[g] = 1'b1;
    step_cen();
    chk("rq_low", int'(busrq_n[g]), 0);
    chk("busy_on", int'(busy[g]), 1);
    repeat (gdly) step_cen();
    chk("req_cs", int'(dma_cs[g]), 0);
    chk("req_rq", int'(busrq_n[g]), 0);
    chk("req_nowr", wcnt[g], 0);
    busak_n[g] = 1'b0;
    step_cen();
    chk("grant_cs", int'(dma_cs[g]), 1);
    chk("grant_ad", int'(ad[g]), 0);
    t0 = cen_cnt;
    n = 0; pdone = 0;
    while (busrq_n[g] == 1'b0 && n < len + 100) begin
      if (ab_at >= 0 && int'(ad[g]) == ab_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_rq", int'(busrq_n[g]), 1);
        chk("rst_cs", int'(dma_cs[g]), 0);
        chk("rst_we", int'(obj_we[g]), 0);
        chk("rst_busy", int'(busy[g]), 0);
        busak_n[g] = 1'b1; vb[g] = 1'b0;
        step_cen();
        rst_n = 1'b1;
        step_cen();
        return;
      end
      if (!pdone && p_len > 0 && int'(ad[g]) == p_at) begin
        pdone = 1;
        busak_n[g] = 1'b1;
        step_cen();
        w0 = wcnt[g];
        repeat (p_len - 1) step_cen();
        chk("pause_ad", int'(ad[g]), p_at);
        busak_n[g] = 1'b0;
        step_cen();
        chk("pause_nowr", wcnt[g], w0);
        n += p_len + 1;
        continue;
      end
      if (rt_at >= 0 && int'(ad[g]) == rt_at)     vb[g] = 1'b0;
      if (rt_at >= 0 && int'(ad[g]) == rt_at + 2) vb[g] = 1'b1;
      step_cen();
      n++;
    end
    chk("done", int'(busrq_n[g]), 1);
    step_cen();
    chk("busy_off", int'(busy[g]), 0);
    chk("cs_off", int'(dma_cs[g]), 0);
    chk("wcnt", wcnt[g], len);
    chk("first_wa", first_wa[g], 0);
    chk("last_wa", last_wa[g], len - 1);
    chk("xfer_cen", last_we_cen[g] - t0, len + 1 + p_len);
    chk("rel_cen", rq_rise_cen[g] - last_we_cen[g], 1);
    chk("rq_falls", rqfall[g], 1);
    nd = 0; nc = 0;
    for (int a = 0; a < len; a++) begin
      if (objram[g][a] != 8'(a)) nd++;
      if (objcnt[g][a] != 1) nc++;
    end
    chk("data_bad", nd, 0);
    chk("wr_count_bad", nc, 0);
    if (g == 1) chk("max_ad", max_ad[g], 1023);
    vb[g] = 1'b0; busak_n[g] = 1'b1;
    step_cen(); step_cen();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vb = 2'b00; busak_n = 2'b11; clr = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busrq_n", int'(busrq_n[0]), 1);
    chk("rst_dma_cs", int'(dma_cs[0]), 0);
    chk("rst_ad", int'(ad[0]), 0);
    chk("rst_oaddr", int'(oaddr[0]), 0);
    chk("rst_odin", int'(odin[0]), 0);
    chk("rst_we", int'(obj_we[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    rst_n = 1'b1;
    step_cen(); step_cen();
    clr = 2'b00;

    run(0, 2, -1, 0, -1, -1);    // nominal
    run(0, 2, -1, 0, 200, -1);   // retrigger mid-transfer is dropped
    run(0, 2, 100, 5, -1, -1);   // bus lost for 5 cen at cnt=100
    run(1, 2, -1, 0, -1, -1);    // LEN=1024 boundary
    run(0, 2, -1, 0, -1, 300);   // reset mid-transfer
    run(0, 2, -1, 0, -1, -1);    // restart from address 0
    run(0, 50, -1, 0, -1, -1);   // slow grant

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
